// File: rtl/sparse_pkg.sv
// Shared types and width helpers for the sparse cluster compactor.
// Included first so every other file can import it.
package sparse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // floor(log2(n))+1, wide enough to hold the value n itself
  function automatic int idx_bits(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sparse_cluster_compactor_if.sv
// Block-in / beat-out handshake bundle for the sparse cluster compactor.
// The master modport is the traffic side, the slave modport is the compactor.
interface sparse_cluster_compactor_if
  import sparse_pkg::*;
#(
  parameter int BITMASK_LENGTH = 8,
  parameter int ELEMENT_WIDTH  = 16,
  parameter int NUM_OUTPUT     = 2,
  parameter int COUNT_BITWIDTH = cnt_bits(NUM_OUTPUT)
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0] in_data;
  logic [BITMASK_LENGTH-1:0]               in_mask;
  logic                                    in_last;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [ELEMENT_WIDTH*NUM_OUTPUT-1:0]     out_data;
  logic [COUNT_BITWIDTH-1:0]               out_count;
  logic                                    out_last;

  modport master (
    output in_valid, in_data, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/sparse_extract_window.sv
// Picks up to NUM_OUTPUT set-mask elements at or after start_i, oldest
// first, and reports where the next scan must resume.
module sparse_extract_window
  import sparse_pkg::*;
#(
  parameter int BITMASK_LENGTH = 8,
  parameter int ELEMENT_WIDTH  = 16,
  parameter int NUM_OUTPUT     = 2,
  parameter int INDEX_BITWIDTH = idx_bits(BITMASK_LENGTH),
  parameter int COUNT_BITWIDTH = cnt_bits(NUM_OUTPUT)
) (
  input  logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0] data_i,
  input  logic [BITMASK_LENGTH-1:0]               mask_i,
  input  logic [INDEX_BITWIDTH-1:0]               start_i,
  output logic [ELEMENT_WIDTH*NUM_OUTPUT-1:0]     elems_o,
  output logic [COUNT_BITWIDTH-1:0]               count_o,
  output logic [INDEX_BITWIDTH-1:0]               next_o,
  output logic                                    more_o
);
  localparam int BL = BITMASK_LENGTH;
  localparam int EW = ELEMENT_WIDTH;
  localparam int NO = NUM_OUTPUT;
  localparam int IW = INDEX_BITWIDTH;
  localparam int CW = COUNT_BITWIDTH;

  logic [BL-1:0] sel;
  logic [IW-1:0] rank [BL];
  logic [IW-1:0] cnt;

  // rank[i] is the output lane element i lands in, if selected
  always_comb begin
    sel     = '0;
    cnt     = '0;
    next_o  = start_i;
    elems_o = '0;
    for (int i = 0; i < BL; i++) begin
      rank[i] = cnt;
      sel[i]  = mask_i[i] && (IW'(i) >= start_i);
      if (sel[i]) begin
        if (cnt < IW'(NO)) next_o = IW'(i + 1);
        cnt = cnt + IW'(1);
      end
    end
    for (int k = 0; k < NO; k++) begin
      for (int i = 0; i < BL; i++) begin
        if (sel[i] && rank[i] == IW'(k)) begin
          elems_o[k*EW +: EW] = data_i[i*EW +: EW];
        end
      end
    end
    count_o = (cnt < IW'(NO)) ? CW'(cnt) : CW'(NO);
    more_o  = cnt > IW'(NO);
  end

endmodule

// File: rtl/sparse_cluster_compactor.sv
// Compacts masked sparse blocks into dense NUM_OUTPUT-wide beats,
// carrying leftovers across blocks until the stream's last block.
module sparse_cluster_compactor
  import sparse_pkg::*;
#(
  parameter int BITMASK_LENGTH = 8,
  parameter int ELEMENT_WIDTH  = 16,
  parameter int NUM_OUTPUT     = 2,
  parameter int INDEX_BITWIDTH = idx_bits(BITMASK_LENGTH),
  parameter int COUNT_BITWIDTH = cnt_bits(NUM_OUTPUT)
) (
  input logic clock,
  input logic reset,
  sparse_cluster_compactor_if.slave bus
);
  localparam int BL = BITMASK_LENGTH;
  localparam int EW = ELEMENT_WIDTH;
  localparam int NO = NUM_OUTPUT;
  localparam int IW = INDEX_BITWIDTH;
  localparam int CW = COUNT_BITWIDTH;
  localparam int RN = 2*NO - 1;
  localparam int RW = $clog2(2*NO);
  localparam logic [RW-1:0] NO_R = RW'(NO);

  state_e             state_q, state_d;
  logic [IW-1:0]      sidx_q, sidx_d;
  logic [BL*EW-1:0]   data_q;
  logic [BL-1:0]      mask_q;
  logic               last_q;
  logic [EW-1:0]      res_q [RN];
  logic [EW-1:0]      res_d [RN];
  logic [RW-1:0]      rcnt_q, rcnt_d, rc_after, wi;
  logic               ov_q, ov_d, ol_q, ol_d;
  logic [NO*EW-1:0]   od_q, od_d;
  logic [CW-1:0]      oc_q, oc_d;
  logic [NO*EW-1:0]   win_elems;
  logic [CW-1:0]      win_cnt;
  logic [IW-1:0]      win_next;
  logic               win_more;
  logic               accept, out_free, pop, scan, flush;

  sparse_extract_window #(
    .BITMASK_LENGTH(BL), .ELEMENT_WIDTH(EW), .NUM_OUTPUT(NO),
    .INDEX_BITWIDTH(IW), .COUNT_BITWIDTH(CW)
  ) u_win (
    .data_i (data_q),
    .mask_i (mask_q),
    .start_i(sidx_q),
    .elems_o(win_elems),
    .count_o(win_cnt),
    .next_o (win_next),
    .more_o (win_more)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_count = oc_q;
  assign bus.out_last  = ol_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_free = !ov_q || bus.out_ready;
  assign pop      = (rcnt_q >= NO_R) && out_free;
  assign rc_after = pop ? rcnt_q - NO_R : rcnt_q;
  assign scan     = (state_q == ST_SCAN) && (rc_after < NO_R);
  assign flush    = (state_q == ST_FLUSH) && (rcnt_q < NO_R) && out_free;

  // pop shifts first, then the scan appends behind what is left
  always_comb begin
    res_d  = res_q;
    rcnt_d = rc_after;
    od_d   = od_q;
    oc_d   = oc_q;
    ol_d   = ol_q;
    ov_d   = ov_q && !bus.out_ready;
    wi     = '0;
    if (pop) begin
      for (int i = 0; i < NO; i++) od_d[i*EW +: EW] = res_q[i];
      for (int i = 0; i < NO - 1; i++) res_d[i] = res_q[i+NO];
      for (int i = NO - 1; i < RN; i++) res_d[i] = '0;
      oc_d = CW'(NO);
      ol_d = 1'b0;
      ov_d = 1'b1;
    end
    if (flush) begin
      for (int i = 0; i < NO; i++) begin
        od_d[i*EW +: EW] = (RW'(i) < rcnt_q) ? res_q[i] : '0;
      end
      for (int i = 0; i < RN; i++) res_d[i] = '0;
      oc_d   = CW'(rcnt_q);
      ol_d   = 1'b1;
      ov_d   = 1'b1;
      rcnt_d = '0;
    end
    if (scan) begin
      for (int j = 0; j < NO; j++) begin
        if (CW'(j) < win_cnt) begin
          wi        = rc_after + RW'(j);
          res_d[wi] = win_elems[j*EW +: EW];
        end
      end
      rcnt_d = rc_after + RW'(win_cnt);
    end
  end

  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SCAN;
          sidx_d  = '0;
        end
      end
      ST_SCAN: begin
        if (scan) begin
          sidx_d = win_next;
          if (!win_more) state_d = last_q ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sidx_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      rcnt_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oc_q    <= '0;
      ol_q    <= 1'b0;
      for (int i = 0; i < RN; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sidx_q  <= sidx_d;
      rcnt_q  <= rcnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oc_q    <= oc_d;
      ol_q    <= ol_d;
      for (int i = 0; i < RN; i++) res_q[i] <= res_d[i];
      if (accept) begin
        data_q <= bus.in_data;
        mask_q <= bus.in_mask;
        last_q <= bus.in_last;
      end
    end
  end

endmodule
